arith_decode_stage: RTL
=======================

Name: arith_decode_stage

Overview:
Registered, parametrised decode stage for integer register/immediate arithmetic in the RV core. It accepts raw 32-bit instructions over a valid/ready handshake. It decodes OP, OP-IMM and optional M-extension and RV64 word forms into an operation kind, register indices and an immediate. Results are presented one cycle later through a 2-entry skid buffer, so back-pressure from execute never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64; 64 enables OP-32/OP-IMM-32 and 6-bit shamt.
ENABLE_M, 1, 1 decodes the M extension (funct7 = 0000001); 0 flags those encodings illegal.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  instruction present.
in_ready  out  1  stage can accept; registered.
in_instr  in  32  raw instruction word.
out_valid  out  1  decoded result present.
out_ready  in  1  consumer accepts the result.
out_kind  out  5  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 mul, 11 mulh, 12 mulhsu, 13 mulhu, 14 div, 15 divu, 16 rem, 17 remu, 31 none.
out_rd  out  5  instr[11:7].
out_rs1  out  5  instr[19:15].
out_rs2  out  5  instr[24:20]; 0 when out_is_imm.
out_imm  out  XLEN  sign-extended I-immediate; for shifts, zero-extended shamt.
out_is_imm  out  1  OP-IMM or OP-IMM-32.
out_is_word  out  1  OP-32 or OP-IMM-32; always 0 when XLEN=32.
out_illegal  out  1  encoding is not a legal arithmetic instruction.

Behaviour:
- Reset: on clk edge with rst=1, clear every output and all skid state.
  - out_valid=0, in_ready=0, out_kind=31, all other outputs 0.
  - In the first cycle after rst deasserts, in_ready=1.
  - rst mid-transfer discards all held entries. Nothing is emitted afterwards.
- Transfers:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - out_* fields are stable while out_valid=1 and out_ready=0.
- Storage: output register (OR) plus one skid entry (SK).
  - Accepted instruction is decoded combinationally and written to OR if OR is empty or being drained this cycle; otherwise it is written to SK.
  - On OR drain with SK full, SK moves into OR.
  - in_ready (registered) = SK empty next cycle.
  - Latency: 1 cycle input to out_valid. Throughput: 1 per cycle when out_ready=1.
- Simultaneous accept and drain with SK empty: new entry lands in OR; out_valid stays 1.
- Full state (OR and SK held, out_ready=0): in_ready=0. in_valid is ignored, no state change.
- Decode rules (opcode = instr[6:0]):
  - OP 0110011: f7=0000000 gives add/sll/slt/sltu/xor/srl/or/and by f3. f7=0100000 is legal only with f3 000 (sub) or 101 (sra). f7=0000001 with ENABLE_M gives mul..remu by f3.
  - OP-IMM 0010011: f3 000/010/011/100/110/111 give add/slt/sltu/xor/or/and. f3 001 requires instr[31:26]=0 (sll). f3 101 with instr[31:26]=000000 gives srl; 010000 gives sra.
  - For XLEN=32, shift-immediates also require instr[25]=0.
  - OP-32 0111011 / OP-IMM-32 0011011 (XLEN=64 only):
    - f7=0000000: f3 000/001/101 give add/sll/srl. OP-32 alone also accepts f7=0100000 with f3 000/101 (sub/sra).
    - OP-IMM-32 shifts require instr[31:25]=0000000 (srl) or 0100000 (sra).
    - With ENABLE_M, f7=0000001 in OP-32 accepts f3 000/100/101/110/111 only (mul/div/divu/rem/remu).
  - Any other combination: out_illegal=1, out_kind=31. Register fields still pass through. The entry still travels the pipeline.
- Immediate: imm = sign-extended instr[31:20]. For shifts, imm = shamt, which is 5 bits for XLEN=32 and for word shifts, 6 bits otherwise.

Test Plan:
- Reset then single accept: after rst, in_instr=0x002081B3 with out_ready=1. Next cycle out_valid=1, kind=0, rd=3, rs1=1, rs2=2, illegal=0. Repeat with 0x402081B3 → kind=1.
- Immediate and shift decode: 0xFFF00093 → kind=0, is_imm=1, rd=1, imm=all ones (XLEN). 0x40335293 → kind=7, rs1=6, rd=5, imm=3, rs2=0.
- M and illegal: 0x022081B3 → kind=10 with ENABLE_M=1; illegal=1, kind=31 with ENABLE_M=0. 0xFE2081B3 → illegal=1 for both settings.
- Back-pressure: stream 0x002081B3, 0x402081B3, 0x022081B3 with out_ready=0. Two are accepted, then in_ready=0. Raise out_ready: the three emerge in order (kinds 0, 1, 10) with no duplicates or gaps.
- Reset mid-operation: OR and SK full, assert rst one cycle. out_valid=0 and in_ready=0 that cycle. The old entries never appear; in_ready=1 the following cycle.
- XLEN=64 word forms: 0x402081BB → kind=1, is_word=1. 0x0020A1BB (OP-32 slt) → illegal=1. Under XLEN=32, 0x0020A1BB → illegal=1 and 0x02009093 (slli shamt 32) → illegal=1.

Source files
------------

// File: rtl/arith_decode_stage_if.sv
// Handshake bundle for the arithmetic decode stage.
// The slave view belongs to the stage; the master view belongs to whoever
// feeds instructions in and takes decoded results out.
interface arith_decode_stage_if #(
    parameter int XLEN = 32
);
    // Instruction side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;

    // Decoded result side
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_kind;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_is_imm;
    logic            out_is_word;
    logic            out_illegal;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_kind,
        output out_rd,
        output out_rs1,
        output out_rs2,
        output out_imm,
        output out_is_imm,
        output out_is_word,
        output out_illegal
    );

    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_kind,
        input  out_rd,
        input  out_rs1,
        input  out_rs2,
        input  out_imm,
        input  out_is_imm,
        input  out_is_word,
        input  out_illegal
    );
endinterface

// File: rtl/arith_decode_stage.sv
// Registered decode stage for RV integer register/immediate arithmetic.
// Decodes OP / OP-IMM (plus OP-32 / OP-IMM-32 when XLEN=64, and the M
// extension when enabled) and presents the result through an output
// register backed by one skid entry, so back-pressure never loses or
// repeats an instruction.
module arith_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    arith_decode_stage_if.slave bus
);
    localparam bit IS_RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [4:0] K_ADD  = 5'd0;
    localparam logic [4:0] K_SUB  = 5'd1;
    localparam logic [4:0] K_SLL  = 5'd2;
    localparam logic [4:0] K_SLT  = 5'd3;
    localparam logic [4:0] K_SLTU = 5'd4;
    localparam logic [4:0] K_XOR  = 5'd5;
    localparam logic [4:0] K_SRL  = 5'd6;
    localparam logic [4:0] K_SRA  = 5'd7;
    localparam logic [4:0] K_OR   = 5'd8;
    localparam logic [4:0] K_AND  = 5'd9;
    localparam logic [4:0] K_MUL  = 5'd10;
    localparam logic [4:0] K_NONE = 5'd31;

    typedef struct packed {
        logic [4:0]      kind;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            is_imm;
        logic            is_word;
        logic            illegal;
    } entry_t;

    // funct3 -> kind for the plain (funct7 = 0) ALU group
    function automatic logic [4:0] base_kind(input logic [2:0] f3);
        logic [4:0] k;
        case (f3)
            3'b000:  k = K_ADD;
            3'b001:  k = K_SLL;
            3'b010:  k = K_SLT;
            3'b011:  k = K_SLTU;
            3'b100:  k = K_XOR;
            3'b101:  k = K_SRL;
            3'b110:  k = K_OR;
            default: k = K_AND;
        endcase
        return k;
    endfunction

    logic [31:0]     w_instr;
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [5:0]      w_shamt_wide;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_imm_sext;
    logic            w_shamt_ok;
    logic            w_legal;
    logic [4:0]      w_kind;
    logic            w_is_imm;
    logic            w_is_word;
    logic            w_shift_imm;
    entry_t          w_dec;

    assign w_instr  = bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];

    assign w_imm_sext = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};

    // Full-width shifts take a 6-bit shamt on RV64; on RV32 bit 25 must be
    // zero and only 5 bits of shift amount exist.
    generate
        if (IS_RV64) begin : g_rv64_shamt
            assign w_shamt_wide = w_instr[25:20];
            assign w_shamt_ok   = 1'b1;
        end else begin : g_rv32_shamt
            assign w_shamt_wide = {1'b0, w_instr[24:20]};
            assign w_shamt_ok   = ~w_instr[25];
        end
    endgenerate

    // Classify the instruction word into operation kind and form flags
    always_comb begin
        w_legal     = 1'b0;
        w_kind      = K_NONE;
        w_is_imm    = 1'b0;
        w_is_word   = 1'b0;
        w_shift_imm = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    w_kind  = base_kind(w_f3);
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_legal = 1'b1;
                    w_kind  = (w_f3 == 3'b000) ? K_SUB : K_SRA;
                end else if (w_f7 == 7'b0000001 && ENABLE_M) begin
                    w_legal = 1'b1;
                    w_kind  = K_MUL + {2'b00, w_f3};
                end
            end
            OPC_OP_IMM: begin
                w_is_imm = 1'b1;
                case (w_f3)
                    3'b001: begin
                        if (w_shamt_ok && w_instr[31:26] == 6'b000000) begin
                            w_legal     = 1'b1;
                            w_kind      = K_SLL;
                            w_shift_imm = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (w_shamt_ok && w_instr[31:26] == 6'b000000) begin
                            w_legal     = 1'b1;
                            w_kind      = K_SRL;
                            w_shift_imm = 1'b1;
                        end else if (w_shamt_ok && w_instr[31:26] == 6'b010000) begin
                            w_legal     = 1'b1;
                            w_kind      = K_SRA;
                            w_shift_imm = 1'b1;
                        end
                    end
                    default: begin
                        w_legal = 1'b1;
                        w_kind  = base_kind(w_f3);
                    end
                endcase
            end
            OPC_OP_32: begin
                if (IS_RV64) begin
                    w_is_word = 1'b1;
                    if (w_f7 == 7'b0000000 &&
                        (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101)) begin
                        w_legal = 1'b1;
                        w_kind  = base_kind(w_f3);
                    end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                        w_legal = 1'b1;
                        w_kind  = (w_f3 == 3'b000) ? K_SUB : K_SRA;
                    end else if (w_f7 == 7'b0000001 && ENABLE_M &&
                                 (w_f3 == 3'b000 || w_f3[2])) begin
                        // mulw plus the four divide/remainder word forms
                        w_legal = 1'b1;
                        w_kind  = K_MUL + {2'b00, w_f3};
                    end
                end
            end
            OPC_OP_IMM_32: begin
                if (IS_RV64) begin
                    w_is_imm  = 1'b1;
                    w_is_word = 1'b1;
                    case (w_f3)
                        3'b000: begin
                            w_legal = 1'b1;
                            w_kind  = K_ADD;
                        end
                        3'b001: begin
                            if (w_f7 == 7'b0000000) begin
                                w_legal     = 1'b1;
                                w_kind      = K_SLL;
                                w_shift_imm = 1'b1;
                            end
                        end
                        3'b101: begin
                            if (w_f7 == 7'b0000000) begin
                                w_legal     = 1'b1;
                                w_kind      = K_SRL;
                                w_shift_imm = 1'b1;
                            end else if (w_f7 == 7'b0100000) begin
                                w_legal     = 1'b1;
                                w_kind      = K_SRA;
                                w_shift_imm = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Assemble the decoded entry; word shifts only ever use 5 shamt bits
    always_comb begin
        w_shamt       = w_is_word ? {1'b0, w_instr[24:20]} : w_shamt_wide;
        w_dec.kind    = w_legal ? w_kind : K_NONE;
        w_dec.rd      = w_instr[11:7];
        w_dec.rs1     = w_instr[19:15];
        w_dec.rs2     = w_is_imm ? 5'd0 : w_instr[24:20];
        w_dec.imm     = w_shift_imm ? {{(XLEN-6){1'b0}}, w_shamt} : w_imm_sext;
        w_dec.is_imm  = w_is_imm;
        w_dec.is_word = w_is_word;
        w_dec.illegal = ~w_legal;
    end

    // ---------------------------------------------------------------
    // Output register (OR) + skid entry (SK)
    // ---------------------------------------------------------------
    entry_t r_or;
    entry_t r_sk;
    logic   r_or_valid;
    logic   r_sk_valid;
    logic   r_in_ready;

    entry_t w_or_next;
    entry_t w_sk_next;
    logic   w_or_valid_next;
    logic   w_sk_valid_next;
    logic   w_accept;
    logic   w_drain;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_drain  = r_or_valid & bus.out_ready;

    // Route accepted entries: OR when it frees up this cycle, SK otherwise;
    // a held SK entry always has priority for the freed OR slot.
    always_comb begin
        w_or_next       = r_or;
        w_sk_next       = r_sk;
        w_or_valid_next = r_or_valid;
        w_sk_valid_next = r_sk_valid;
        if (!r_or_valid || w_drain) begin
            if (r_sk_valid) begin
                w_or_next       = r_sk;
                w_or_valid_next = 1'b1;
                w_sk_valid_next = 1'b0;
            end else if (w_accept) begin
                w_or_next       = w_dec;
                w_or_valid_next = 1'b1;
            end else begin
                w_or_valid_next = 1'b0;
            end
        end else if (w_accept) begin
            w_sk_next       = w_dec;
            w_sk_valid_next = 1'b1;
        end
    end

    // Register the storage; reset empties both slots and holds off input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_or       <= '{kind: K_NONE, default: '0};
            r_sk       <= '{kind: K_NONE, default: '0};
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_or       <= w_or_next;
            r_sk       <= w_sk_next;
            r_or_valid <= w_or_valid_next;
            r_sk_valid <= w_sk_valid_next;
            r_in_ready <= ~w_sk_valid_next;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_or_valid;
    assign bus.out_kind    = r_or.kind;
    assign bus.out_rd      = r_or.rd;
    assign bus.out_rs1     = r_or.rs1;
    assign bus.out_rs2     = r_or.rs2;
    assign bus.out_imm     = r_or.imm;
    assign bus.out_is_imm  = r_or.is_imm;
    assign bus.out_is_word = r_or.is_word;
    assign bus.out_illegal = r_or.illegal;
endmodule
